// File: rtl/rnn_step_sequencer.sv
// rtl/rnn_step_sequencer.sv - RNN timestep sequencer for the shared MAC datapath (optional feature macro: RNN_SEQ_TIMEOUT_EN)
module rnn_step_sequencer #(
    parameter int N_INPUT  = 2,
    parameter int N_HIDDEN = 4,
    parameter int STEP_W   = 4,
`ifdef RNN_SEQ_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 255,
`endif
    localparam int XA_W = (N_INPUT > 1) ? $clog2(N_INPUT) : 1,
    localparam int HA_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1,
    localparam int KW   = $clog2(N_INPUT + N_HIDDEN),
    localparam int WA_W = $clog2(N_HIDDEN * (N_INPUT + N_HIDDEN)),
    localparam int MX   = (N_INPUT > N_HIDDEN) ? N_INPUT : N_HIDDEN,
    localparam int OA_W = (MX > 1) ? $clog2(MX) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start,
    input  logic [STEP_W-1:0] steps_in,
    input  logic              x_valid,
    output logic              x_ready,
    output logic              x_we,
    output logic [XA_W-1:0]   x_addr,
    output logic              acc_clr,
    output logic              mac_en,
    output logic [WA_W-1:0]   w_addr,
    output logic              op_sel,
    output logic [OA_W-1:0]   op_addr,
    output logic              bias_en,
    output logic              h_we,
    output logic [HA_W-1:0]   h_addr,
    output logic              h_swap,
    output logic              busy,
    output logic              done
`ifdef RNN_SEQ_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_X, S_ROW_INIT, S_MAC, S_BIAS, S_WB, S_SWAP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XA_W-1:0]   i_q, i_d;
    logic [KW-1:0]     k_q, k_d;
    logic [HA_W-1:0]   r_q, r_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] steps_q, steps_d;
    // Weight address tracks r*(N_INPUT+N_HIDDEN)+k by incrementing, so no multiplier is needed.
    logic [WA_W-1:0]   wa_q, wa_d;

    logic              x_ready_q, x_ready_d;
    logic              acc_clr_q, acc_clr_d;
    logic              mac_en_q, mac_en_d;
    logic              bias_en_q, bias_en_d;
    logic              h_we_q, h_we_d;
    logic              h_swap_q, h_swap_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [XA_W-1:0]   x_addr_q, x_addr_d;
    logic [WA_W-1:0]   w_addr_q, w_addr_d;
    logic              op_sel_q, op_sel_d;
    logic [OA_W-1:0]   op_addr_q, op_addr_d;
    logic [HA_W-1:0]   h_addr_q, h_addr_d;
    logic              err_d;

`ifdef RNN_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q;
`endif

    // Strobes are gated by ena so a frozen sequencer never triggers the datapath.
    assign x_ready = x_ready_q & ena;
    assign x_we    = x_valid & x_ready;
    assign acc_clr = acc_clr_q & ena;
    assign mac_en  = mac_en_q & ena;
    assign bias_en = bias_en_q & ena;
    assign h_we    = h_we_q & ena;
    assign h_swap  = h_swap_q & ena;
    assign done    = done_q & ena;
    assign busy    = busy_q;
    assign x_addr  = x_addr_q;
    assign w_addr  = w_addr_q;
    assign op_sel  = op_sel_q;
    assign op_addr = op_addr_q;
    assign h_addr  = h_addr_q;
`ifdef RNN_SEQ_TIMEOUT_EN
    assign err     = err_q & ena;
`endif

    // Next-state and counter update for the step/row/operand walk.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        r_d     = r_q;
        step_d  = step_q;
        steps_d = steps_q;
        wa_d    = wa_q;
        err_d   = 1'b0;
`ifdef RNN_SEQ_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    steps_d = (steps_in == '0) ? STEP_W'(1) : steps_in;
                    step_d  = '0;
                    i_d     = '0;
                    state_d = S_WAIT_X;
`ifdef RNN_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_WAIT_X: begin
                if (x_we) begin
`ifdef RNN_SEQ_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (i_q == XA_W'(N_INPUT - 1)) begin
                        i_d     = '0;
                        r_d     = '0;
                        wa_d    = '0;
                        state_d = S_ROW_INIT;
                    end else begin
                        i_d = i_q + XA_W'(1);
                    end
                end else begin
`ifdef RNN_SEQ_TIMEOUT_EN
                    // Abandon the run quietly: no swap, no done, just an err pulse.
                    if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                        i_d     = '0;
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
            end
            S_ROW_INIT: begin
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                wa_d = wa_q + WA_W'(1);
                if (k_q == KW'(N_INPUT + N_HIDDEN - 1)) begin
                    state_d = S_BIAS;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_BIAS: begin
                state_d = S_WB;
            end
            S_WB: begin
                if (r_q == HA_W'(N_HIDDEN - 1)) begin
                    state_d = S_SWAP;
                end else begin
                    r_d     = r_q + HA_W'(1);
                    state_d = S_ROW_INIT;
                end
            end
            S_SWAP: begin
                if (step_q == steps_q - STEP_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    i_d     = '0;
                    state_d = S_WAIT_X;
`ifdef RNN_SEQ_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode from the upcoming state so outputs come straight out of flops.
    always_comb begin
        x_ready_d = 1'b0;
        acc_clr_d = 1'b0;
        mac_en_d  = 1'b0;
        bias_en_d = 1'b0;
        h_we_d    = 1'b0;
        h_swap_d  = 1'b0;
        done_d    = 1'b0;
        busy_d    = (state_d != S_IDLE);
        x_addr_d  = x_addr_q;
        w_addr_d  = w_addr_q;
        op_sel_d  = op_sel_q;
        op_addr_d = op_addr_q;
        h_addr_d  = h_addr_q;
        case (state_d)
            S_WAIT_X: begin
                x_ready_d = 1'b1;
                x_addr_d  = i_d;
            end
            S_ROW_INIT: acc_clr_d = 1'b1;
            S_MAC: begin
                mac_en_d = 1'b1;
                w_addr_d = wa_d;
                if (k_d < KW'(N_INPUT)) begin
                    op_sel_d  = 1'b0;
                    op_addr_d = OA_W'(k_d);
                end else begin
                    op_sel_d  = 1'b1;
                    op_addr_d = OA_W'(k_d - KW'(N_INPUT));
                end
            end
            S_BIAS: bias_en_d = 1'b1;
            S_WB: begin
                h_we_d   = 1'b1;
                h_addr_d = r_d;
            end
            S_SWAP: h_swap_d = 1'b1;
            S_DONE: done_d = 1'b1;
            default: begin
            end
        endcase
    end

    // State and counter registers; ena low freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            k_q     <= '0;
            r_q     <= '0;
            step_q  <= '0;
            steps_q <= '0;
            wa_q    <= '0;
`ifdef RNN_SEQ_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else if (ena) begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            r_q     <= r_d;
            step_q  <= step_d;
            steps_q <= steps_d;
            wa_q    <= wa_d;
`ifdef RNN_SEQ_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Output registers; they hold while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_ready_q <= 1'b0;
            acc_clr_q <= 1'b0;
            mac_en_q  <= 1'b0;
            bias_en_q <= 1'b0;
            h_we_q    <= 1'b0;
            h_swap_q  <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            x_addr_q  <= '0;
            w_addr_q  <= '0;
            op_sel_q  <= 1'b0;
            op_addr_q <= '0;
            h_addr_q  <= '0;
`ifdef RNN_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else if (ena) begin
            x_ready_q <= x_ready_d;
            acc_clr_q <= acc_clr_d;
            mac_en_q  <= mac_en_d;
            bias_en_q <= bias_en_d;
            h_we_q    <= h_we_d;
            h_swap_q  <= h_swap_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            x_addr_q  <= x_addr_d;
            w_addr_q  <= w_addr_d;
            op_sel_q  <= op_sel_d;
            op_addr_q <= op_addr_d;
            h_addr_q  <= h_addr_d;
`ifdef RNN_SEQ_TIMEOUT_EN
            err_q     <= err_d;
`endif
        end
    end

`ifndef RNN_SEQ_TIMEOUT_EN
    // Without the watchdog there is never an abort to report.
    logic unused_err;
    assign unused_err = err_d;
`endif

endmodule

// File: tb/tb_rnn_step_sequencer.sv
// tb/tb_rnn_step_sequencer.sv - scoreboard bench for rnn_step_sequencer
module tb_rnn_step_sequencer;

    localparam int NI  = 2;
    localparam int NH  = 4;
    localparam int SW  = 4;
    localparam int ROW = NI + NH;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          start;
    logic [SW-1:0] steps_in;
    logic          x_valid;
    logic          x_ready;
    logic          x_we;
    logic [0:0]    x_addr;
    logic          acc_clr;
    logic          mac_en;
    logic [4:0]    w_addr;
    logic          op_sel;
    logic [1:0]    op_addr;
    logic          bias_en;
    logic          h_we;
    logic [1:0]    h_addr;
    logic          h_swap;
    logic          busy;
    logic          done;
`ifdef RNN_SEQ_TIMEOUT_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          obs_cyc[$];

    rnn_step_sequencer #(
        .N_INPUT(NI),
        .N_HIDDEN(NH),
        .STEP_W(SW)
`ifdef RNN_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(10)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .start(start),
        .steps_in(steps_in),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .x_we(x_we),
        .x_addr(x_addr),
        .acc_clr(acc_clr),
        .mac_en(mac_en),
        .w_addr(w_addr),
        .op_sel(op_sel),
        .op_addr(op_addr),
        .bias_en(bias_en),
        .h_we(h_we),
        .h_addr(h_addr),
        .h_swap(h_swap),
        .busy(busy),
        .done(done)
`ifdef RNN_SEQ_TIMEOUT_EN
        ,
        .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Event word: type[15:12] addr[11:4] op_sel[3] op_addr[2:0]
    function automatic logic [15:0] ev(input int t, input int a, input int s, input int o);
        return 16'((t << 12) | (a << 4) | (s << 3) | o);
    endfunction

    // Record every strobe the DUT issues, with the cycle it happened in.
    always @(negedge clk) begin
        if (rst_n) begin
            if (x_we)    begin obs_q.push_back(ev(1, int'(x_addr), 0, 0)); obs_cyc.push_back(cyc); end
            if (acc_clr) begin obs_q.push_back(ev(2, 0, 0, 0)); obs_cyc.push_back(cyc); end
            if (mac_en)  begin obs_q.push_back(ev(3, int'(w_addr), int'(op_sel), int'(op_addr))); obs_cyc.push_back(cyc); end
            if (bias_en) begin obs_q.push_back(ev(4, 0, 0, 0)); obs_cyc.push_back(cyc); end
            if (h_we)    begin obs_q.push_back(ev(5, int'(h_addr), 0, 0)); obs_cyc.push_back(cyc); end
            if (h_swap)  begin obs_q.push_back(ev(6, 0, 0, 0)); obs_cyc.push_back(cyc); end
            if (done)    begin obs_q.push_back(ev(7, 0, 0, 0)); obs_cyc.push_back(cyc); end
        end
    end

    // Reference sequence of one run.
    task automatic push_run(input int steps);
        int st;
        st = (steps == 0) ? 1 : steps;
        for (int s = 0; s < st; s++) begin
            for (int j = 0; j < NI; j++) exp_q.push_back(ev(1, j, 0, 0));
            for (int r = 0; r < NH; r++) begin
                exp_q.push_back(ev(2, 0, 0, 0));
                for (int k = 0; k < ROW; k++)
                    exp_q.push_back(ev(3, r * ROW + k, (k >= NI) ? 1 : 0, (k < NI) ? k : k - NI));
                exp_q.push_back(ev(4, 0, 0, 0));
                exp_q.push_back(ev(5, r, 0, 0));
            end
            exp_q.push_back(ev(6, 0, 0, 0));
        end
        exp_q.push_back(ev(7, 0, 0, 0));
    endtask

    task automatic send_start(input int steps);
        @(posedge clk); #1;
        start    = 1'b1;
        steps_in = SW'(steps);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic feed_x(input int n, input int maxgap, output bit ok);
        bit got;
        ok = 1'b1;
        for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, maxgap)) @(posedge clk);
            #1 x_valid = 1'b1;
            got = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (x_ready) begin got = 1'b1; break; end
            end
            @(posedge clk); #1;
            x_valid = 1'b0;
            if (!got) ok = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL reset_x_ready got %b want 0", x_ready); end
        n_checks++; if (done !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (w_addr !== 5'd0)  begin n_fail++; $display("FAIL reset_w_addr got %0d want 0", w_addr); end
        n_checks++; if (h_addr !== 2'd0)  begin n_fail++; $display("FAIL reset_h_addr got %0d want 0", h_addr); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_single_step();
        bit ok;
        int last_x, swap_c, done_c, oc;
        logic [15:0] e, o;
        last_x = -1; swap_c = -1; done_c = -1;
        push_run(1);
        send_start(1);
        feed_x(NI, 0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_feed got no x_ready want x_ready"); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_done got timeout want done"); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_at_done got %b want 1", busy); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got %b want 0", busy); end
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL single_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); oc = obs_cyc.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL single_event got %h want %h", o, e); end
            if (e[15:12] == 4'd1) last_x = oc;
            if (e[15:12] == 4'd6) swap_c = oc;
            if (e[15:12] == 4'd7) done_c = oc;
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
        n_checks++; if (swap_c - last_x != 37) begin n_fail++; $display("FAIL single_swap_latency got %0d want 37", swap_c - last_x); end
        n_checks++; if (done_c - swap_c != 1)  begin n_fail++; $display("FAIL single_done_latency got %0d want 1", done_c - swap_c); end
    endtask

    task automatic test_multi_step();
        bit ok;
        int n_sw, n_xw, n_hw, n_dn;
        logic [15:0] e, o;
        n_sw = 0; n_xw = 0; n_hw = 0; n_dn = 0;
        push_run(3);
        send_start(3);
        feed_x(3 * NI, 5, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_feed got no x_ready want x_ready"); end
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL multi_done got timeout want done"); end
        repeat (2) @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL multi_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); void'(obs_cyc.pop_front());
            if (o[15:12] == 4'd1) n_xw++;
            if (o[15:12] == 4'd5) n_hw++;
            if (o[15:12] == 4'd6) n_sw++;
            if (o[15:12] == 4'd7) n_dn++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++; if (o !== e) begin n_fail++; $display("FAIL multi_event got %h want %h", o, e); end
            end
        end
        exp_q.delete(); obs_cyc.delete();
        n_checks++; if (n_sw != 3)  begin n_fail++; $display("FAIL multi_swaps got %0d want 3", n_sw); end
        n_checks++; if (n_xw != 6)  begin n_fail++; $display("FAIL multi_x_we got %0d want 6", n_xw); end
        n_checks++; if (n_hw != 12) begin n_fail++; $display("FAIL multi_h_we got %0d want 12", n_hw); end
        n_checks++; if (n_dn != 1)  begin n_fail++; $display("FAIL multi_done got %0d want 1", n_dn); end
    endtask

    task automatic test_steps_zero();
        bit ok;
        logic [15:0] e, o;
        push_run(0);
        send_start(0);
        feed_x(NI, 2, ok);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_done got timeout want done"); end
        repeat (3) @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL zero_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL zero_event got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_ena_pause();
        bit ok, got;
        logic [15:0] e, o;
        push_run(1);
        send_start(1);
        feed_x(1, 0, ok);
        x_valid = 1'b1;
        ena     = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ((x_ready | x_we | acc_clr | mac_en | bias_en | h_we | h_swap | done) !== 1'b0)
                begin n_fail++; $display("FAIL ena_waitx_strobes got 1 want 0"); end
            n_checks++; if (x_addr !== 1'b1) begin n_fail++; $display("FAIL ena_waitx_addr got %0d want 1", x_addr); end
        end
        @(posedge clk); #1 ena = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (x_ready) begin got = 1'b1; break; end
        end
        @(posedge clk); #1 x_valid = 1'b0;
        n_checks++; if (!got) begin n_fail++; $display("FAIL ena_resume_x got no x_ready want x_ready"); end
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mac_en && w_addr == 5'd2) begin got = 1'b1; break; end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL ena_find_mac got timeout want w_addr 2"); end
        @(posedge clk); #1 ena = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ((x_ready | x_we | acc_clr | mac_en | bias_en | h_we | h_swap | done) !== 1'b0)
                begin n_fail++; $display("FAIL ena_mac_strobes got 1 want 0"); end
            n_checks++; if (w_addr !== 5'd3) begin n_fail++; $display("FAIL ena_mac_addr got %0d want 3", w_addr); end
        end
        @(posedge clk); #1 ena = 1'b1;
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ena_done got timeout want done"); end
        @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ena_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL ena_event got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid_mac();
        bit ok, got;
        logic [15:0] e, o;
        send_start(1);
        feed_x(NI, 0, ok);
        got = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mac_en && w_addr == 5'd3) begin got = 1'b1; break; end
        end
        n_checks++; if (!got) begin n_fail++; $display("FAIL rstmac_find got timeout want w_addr 3"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rstmac_busy got %b want 0", busy); end
        n_checks++; if (mac_en !== 1'b0)  begin n_fail++; $display("FAIL rstmac_mac_en got %b want 0", mac_en); end
        n_checks++; if (w_addr !== 5'd0)  begin n_fail++; $display("FAIL rstmac_w_addr got %0d want 0", w_addr); end
        n_checks++; if (op_sel !== 1'b0)  begin n_fail++; $display("FAIL rstmac_op_sel got %b want 0", op_sel); end
        n_checks++; if (op_addr !== 2'd0) begin n_fail++; $display("FAIL rstmac_op_addr got %0d want 0", op_addr); end
        @(posedge clk); #1 rst_n = 1'b1;
        obs_q.delete(); obs_cyc.delete(); exp_q.delete();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmac_release_busy got %b want 0", busy); end
        push_run(1);
        send_start(1);
        feed_x(NI, 1, ok);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rstmac_rerun got timeout want done"); end
        @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rstmac_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL rstmac_event got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

`ifdef RNN_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int n_at;
        logic [15:0] e, o;
        n_at = -1;
        send_start(1);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (err) begin n_at = n; break; end
        end
        n_checks++; if (n_at != 10)    begin n_fail++; $display("FAIL tmo_latency got %0d want 10", n_at); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL tmo_err_width got %b want 0", err); end
        repeat (3) @(negedge clk);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL tmo_events got %0d want 0", obs_q.size()); end
        obs_q.delete(); obs_cyc.delete();
        push_run(1);
        send_start(1);
        feed_x(NI, 2, ok);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_rerun got timeout want done"); end
        @(negedge clk);
        n_checks++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL tmo_len got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++; if (o !== e) begin n_fail++; $display("FAIL tmo_event got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        start    = 1'b0;
        steps_in = '0;
        x_valid  = 1'b0;
        test_reset();
        test_single_step();
        test_multi_step();
        test_steps_zero();
        test_ena_pause();
        test_reset_mid_mac();
`ifdef RNN_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1);
    end

endmodule
